// File: rtl/xyolo_vmac_pkg.sv
// Shared constants and types for the xyolo_vmac vector MAC stage.
// Optional feature macro (see xyolo_vmac.sv): XYOLO_VMAC_LEAKY_EN.
package xyolo_vmac_pkg;

    localparam int unsigned N_YOLO_VECT = 4;   // default lane count
    localparam int unsigned MEM_ADDR_W  = 10;  // ITER register width
    localparam int unsigned PERIOD_W    = 10;  // PER / DELAY register width
    localparam int unsigned SHIFT_W     = 5;
    localparam int unsigned ADDR_W      = 3;   // config register select width

    localparam logic [ADDR_W-1:0] CONF_ITER  = 3'd0;
    localparam logic [ADDR_W-1:0] CONF_PER   = 3'd1;
    localparam logic [ADDR_W-1:0] CONF_DELAY = 3'd2;
    localparam logic [ADDR_W-1:0] CONF_SHIFT = 3'd3;
    localparam logic [ADDR_W-1:0] CONF_LEAKY = 3'd4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StAcc   = 2'd2,
        StDrain = 2'd3
    } state_e;

endpackage

// File: rtl/xyolo_vmac_if.sv
// CPU configuration request bus for xyolo_vmac.
//   valid : request strobe
//   addr  : config register select
//   wdata : write data
//   wstrb : write enable (write happens on valid & wstrb)
// master drives the bus, slave (the vmac) receives it.
interface xyolo_vmac_if
    import xyolo_vmac_pkg::*;
#(
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wstrb;

    modport master (output valid, output addr, output wdata, output wstrb);
    modport slave  (input valid, input addr, input wdata, input wstrb);
endinterface

// File: rtl/xyolo_vmac_lane.sv
// One lane of the vector MAC: S1 multiply, S2 bias-seeded accumulate, S3 shift/saturate.
// Ports:
//   clk, rst        clock, async active-high reset
//   s0_first_i      current input sample starts a period (bias is captured now)
//   s1_valid_i      S1 holds a valid product
//   s1_first_i      S1 product is the first of its period
//   s2_last_i       accumulator holds the final sum of a period
//   shift_i         arithmetic right shift applied to the sum
//   leaky_i         (XYOLO_VMAC_LEAKY_EN builds only) scale negative results by 13/128
//   pixel_i         broadcast pixel, [15:0] signed used
//   weight_i        lane weight, [15:0] signed used
//   bias_i          lane bias, full-width signed
//   flow_o          16-bit saturated result, sign-extended; holds between updates
module xyolo_vmac_lane
    import xyolo_vmac_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s0_first_i,
    input  logic               s1_valid_i,
    input  logic               s1_first_i,
    input  logic               s2_last_i,
    input  logic [SHIFT_W-1:0] shift_i,
`ifdef XYOLO_VMAC_LEAKY_EN
    input  logic               leaky_i,
`endif
    input  logic [DATA_W-1:0]  pixel_i,
    input  logic [DATA_W-1:0]  weight_i,
    input  logic [DATA_W-1:0]  bias_i,
    output logic [DATA_W-1:0]  flow_o
);

    localparam int unsigned RW = ACC_W + 4;  // headroom for the x13 leaky scale
    localparam logic signed [RW-1:0] SatMax = RW'(32767);
    localparam logic signed [RW-1:0] SatMin = -RW'(32768);

    logic [31:0]              prod_q, prod_d;
    logic [DATA_W-1:0]        bias_q;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [DATA_W-1:0]        out_q;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [RW-1:0]     r_ext, r_fin;
    logic signed [15:0]       r_sat;
    logic                     unused_hi;

    assign unused_hi = ^{pixel_i[DATA_W-1:16], weight_i[DATA_W-1:16]};

    // Two's-complement product of sign-extended operands, taken mod 2^32.
    assign prod_d = {{16{weight_i[15]}}, weight_i[15:0]} * {{16{pixel_i[15]}}, pixel_i[15:0]};

    always_comb begin
        acc_d = acc_q;
        if (s1_valid_i) begin
            if (s1_first_i) begin
                acc_d = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q}
                      + {{(ACC_W-32){prod_q[31]}}, prod_q};
            end else begin
                acc_d = acc_q + {{(ACC_W-32){prod_q[31]}}, prod_q};
            end
        end
    end

    always_comb begin
        shifted = $signed(acc_q) >>> shift_i;
        r_ext   = {{4{shifted[ACC_W-1]}}, shifted};
`ifdef XYOLO_VMAC_LEAKY_EN
        // r*13/128 via shifts; >>> floors toward -inf
        if (leaky_i && r_ext[RW-1]) begin
            r_fin = ((r_ext <<< 3) + (r_ext <<< 2) + r_ext) >>> 7;
        end else begin
            r_fin = r_ext;
        end
`else
        r_fin = r_ext;
`endif
        if (r_fin > SatMax) begin
            r_sat = 16'sh7fff;
        end else if (r_fin < SatMin) begin
            r_sat = 16'sh8000;
        end else begin
            r_sat = r_fin[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            bias_q <= '0;
            acc_q  <= '0;
            out_q  <= '0;
        end else begin
            prod_q <= prod_d;
            if (s0_first_i) bias_q <= bias_i;
            acc_q  <= acc_d;
            if (s2_last_i) out_q <= {{(DATA_W-16){r_sat[15]}}, r_sat};
        end
    end

    assign flow_o = out_q;

endmodule

// File: rtl/xyolo_vmac.sv
// Vector multiply-accumulate stage: N_LANES lanes of weight*pixel, bias-seeded per period,
// shifted and saturated to 16 bits. Configured over the CPU request bus, started by run_i.
// Optional feature macro: XYOLO_VMAC_LEAKY_EN adds the LEAKY config register.
// Ports:
//   clk, rst            clock, async active-high reset
//   clear_i             async clear of the config registers only
//   run_i               start pulse (IDLE only, needs ITER!=0 and PER!=0)
//   done_o              high while idle with the pipeline empty
//   cpu_if              config bus (slave)
//   flow_in_pixel_i     broadcast pixel
//   flow_in_bias_i      per-lane bias, lane 0 at MSBs
//   flow_in_weight_i    per-lane weight, lane 0 at MSBs
//   flow_out_o          per-lane result, lane 0 at MSBs
//   flow_out_valid_o    1-cycle strobe per accumulation period
module xyolo_vmac
    import xyolo_vmac_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned N_LANES = N_YOLO_VECT,
    parameter int unsigned ACC_W   = 40
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic                      run_i,
    output logic                      done_o,
    xyolo_vmac_if.slave               cpu_if,
    input  logic [DATA_W-1:0]         flow_in_pixel_i,
    input  logic [N_LANES*DATA_W-1:0] flow_in_bias_i,
    input  logic [N_LANES*DATA_W-1:0] flow_in_weight_i,
    output logic [N_LANES*DATA_W-1:0] flow_out_o,
    output logic                      flow_out_valid_o
);

    state_e                state_q, state_d;
    logic [MEM_ADDR_W-1:0] iter_cfg_q, iter_sh_q, iter_cnt_q, iter_cnt_d;
    logic [PERIOD_W-1:0]   per_cfg_q, per_sh_q, per_cnt_q, per_cnt_d;
    logic [PERIOD_W-1:0]   delay_cfg_q, delay_sh_q, wait_cnt_q, wait_cnt_d;
    logic [SHIFT_W-1:0]    shift_cfg_q, shift_sh_q;
    logic [1:0]            drain_cnt_q, drain_cnt_d;
    logic                  leaky_sh;
    logic                  cfg_we, start, acc_en, per_last, iter_last;
    logic                  s0_first, s0_last;
    logic                  s1_valid_q, s1_first_q, s1_last_q, s2_last_q, out_valid_q;
    logic                  unused_wdata;

    assign unused_wdata = ^cpu_if.wdata[DATA_W-1:MEM_ADDR_W];
    assign cfg_we = cpu_if.valid & cpu_if.wstrb;
    assign start  = (state_q == StIdle) && run_i && (iter_cfg_q != '0) && (per_cfg_q != '0);

    // Config registers: cleared by rst or clear_i.
    always_ff @(posedge clk or posedge rst or posedge clear_i) begin
        if (rst || clear_i) begin
            iter_cfg_q  <= '0;
            per_cfg_q   <= '0;
            delay_cfg_q <= '0;
            shift_cfg_q <= '0;
        end else if (cfg_we) begin
            case (cpu_if.addr)
                CONF_ITER:  iter_cfg_q  <= cpu_if.wdata[MEM_ADDR_W-1:0];
                CONF_PER:   per_cfg_q   <= cpu_if.wdata[PERIOD_W-1:0];
                CONF_DELAY: delay_cfg_q <= cpu_if.wdata[PERIOD_W-1:0];
                CONF_SHIFT: shift_cfg_q <= cpu_if.wdata[SHIFT_W-1:0];
                default: ;
            endcase
        end
    end

`ifdef XYOLO_VMAC_LEAKY_EN
    logic leaky_cfg_q, leaky_sh_q;

    always_ff @(posedge clk or posedge rst or posedge clear_i) begin
        if (rst || clear_i) begin
            leaky_cfg_q <= 1'b0;
        end else if (cfg_we && (cpu_if.addr == CONF_LEAKY)) begin
            leaky_cfg_q <= cpu_if.wdata[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) leaky_sh_q <= 1'b0;
        else if (start) leaky_sh_q <= leaky_cfg_q;
    end

    assign leaky_sh = leaky_sh_q;
`else
    assign leaky_sh = 1'b0;
`endif

    // Shadows: frozen copy of the config for the duration of a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_sh_q  <= '0;
            per_sh_q   <= '0;
            delay_sh_q <= '0;
            shift_sh_q <= '0;
        end else if (start) begin
            iter_sh_q  <= iter_cfg_q;
            per_sh_q   <= per_cfg_q;
            delay_sh_q <= delay_cfg_q;
            shift_sh_q <= shift_cfg_q;
        end
    end

    assign per_last  = per_cnt_q == (per_sh_q - PERIOD_W'(1));
    assign iter_last = iter_cnt_q == (iter_sh_q - MEM_ADDR_W'(1));

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StWait;
            StWait:  if (wait_cnt_q == delay_sh_q) state_d = StAcc;
            StAcc:   if (per_last && iter_last) state_d = StDrain;
            StDrain: if (drain_cnt_q == 2'd2) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        done_o = (state_q == StIdle);
        acc_en = (state_q == StAcc);
    end

    always_comb begin
        wait_cnt_d  = (state_q == StWait)  ? wait_cnt_q + PERIOD_W'(1) : '0;
        drain_cnt_d = (state_q == StDrain) ? drain_cnt_q + 2'd1 : 2'd0;
        per_cnt_d   = '0;
        iter_cnt_d  = '0;
        if (acc_en) begin
            if (per_last) begin
                iter_cnt_d = iter_last ? '0 : iter_cnt_q + MEM_ADDR_W'(1);
            end else begin
                per_cnt_d  = per_cnt_q + PERIOD_W'(1);
                iter_cnt_d = iter_cnt_q;
            end
        end
    end

    assign s0_first = acc_en && (per_cnt_q == '0);
    assign s0_last  = acc_en && per_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            per_cnt_q   <= '0;
            iter_cnt_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            per_cnt_q   <= per_cnt_d;
            iter_cnt_q  <= iter_cnt_d;
            s1_valid_q  <= acc_en;
            s1_first_q  <= s0_first;
            s1_last_q   <= s0_last;
            s2_last_q   <= s1_last_q;
            out_valid_q <= s2_last_q;
        end
    end

    assign flow_out_valid_o = out_valid_q;

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        localparam int unsigned Lo = (N_LANES - 1 - l) * DATA_W;  // lane 0 at MSBs
        xyolo_vmac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .s0_first_i (s0_first),
            .s1_valid_i (s1_valid_q),
            .s1_first_i (s1_first_q),
            .s2_last_i  (s2_last_q),
            .shift_i    (shift_sh_q),
`ifdef XYOLO_VMAC_LEAKY_EN
            .leaky_i    (leaky_sh),
`endif
            .pixel_i    (flow_in_pixel_i),
            .weight_i   (flow_in_weight_i[Lo +: DATA_W]),
            .bias_i     (flow_in_bias_i[Lo +: DATA_W]),
            .flow_o     (flow_out_o[Lo +: DATA_W])
        );
    end

`ifndef XYOLO_VMAC_LEAKY_EN
    logic unused_leaky;
    assign unused_leaky = leaky_sh;
`endif

endmodule

// File: tb/tb_xyolo_vmac.sv
// Self-checking bench for xyolo_vmac: directed vector table, hand sequences, random jobs
// against a per-period arithmetic reference model.
module tb_xyolo_vmac;
    import xyolo_vmac_pkg::*;

    localparam int DW   = 32;
    localparam int NL   = 4;
    localparam int MAXS = 64;
    localparam int MAXP = 16;

    logic            clk = 1'b0;
    logic            rst, clear, run, done, fov;
    logic [DW-1:0]   pix;
    logic [NL*DW-1:0] bias, wgt, fo;

    xyolo_vmac_if #(.DATA_W(DW)) cpu_if ();

    xyolo_vmac #(.DATA_W(DW), .N_LANES(NL), .ACC_W(40)) dut (
        .clk              (clk),
        .rst              (rst),
        .clear_i          (clear),
        .run_i            (run),
        .done_o           (done),
        .cpu_if           (cpu_if),
        .flow_in_pixel_i  (pix),
        .flow_in_bias_i   (bias),
        .flow_in_weight_i (wgt),
        .flow_out_o       (fo),
        .flow_out_valid_o (fov)
    );

    always #5 clk = ~clk;

    int      n_tests = 0;
    int      n_fail  = 0;
    shortint pix_a [MAXS];
    shortint w_a   [NL][MAXS];
    int      bias_a[MAXP][NL];
    bit      leaky_on = 1'b0;

    typedef struct {
        int per; int shift; int delay; int bias; int w; int pix0; int step; int expv;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected result of period p, lane l: bias + sum(w*pix), >>> shift, optional leaky, saturate.
    function automatic int model(input int l, input int p, input int per, input int shift);
        longint s;
        s = longint'(bias_a[p][l]);
        for (int j = 0; j < per; j++)
            s += longint'(w_a[l][p*per+j]) * longint'(pix_a[p*per+j]);
        s = s >>> shift;
        if (leaky_on && s < 0) s = (s * 13) >>> 7;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    function automatic longint lane_out(input int l);
        logic [DW-1:0] v;
        v = fo[(NL-1-l)*DW +: DW];
        return longint'($signed(v));
    endfunction

    task automatic cfg_write(input logic [ADDR_W-1:0] a, input int d);
        cpu_if.valid = 1'b1;
        cpu_if.wstrb = 1'b1;
        cpu_if.addr  = a;
        cpu_if.wdata = d;
        tick();
        cpu_if.valid = 1'b0;
        cpu_if.wstrb = 1'b0;
    endtask

    task automatic fill_const(input int iter, input int per, input int b, input int w,
                              input int p0, input int step);
        for (int p = 0; p < iter; p++)
            for (int l = 0; l < NL; l++) bias_a[p][l] = b;
        for (int k = 0; k < iter*per; k++) begin
            pix_a[k] = shortint'(p0 + step * (k % per));
            for (int l = 0; l < NL; l++) w_a[l][k] = shortint'(w);
        end
    endtask

    // Run one job; rel 0 is the cycle run is high. Samples k go in at rel 2+delay+k.
    task automatic run_job(input int iter, input int per, input int shift, input int delay,
                           input bit inj_run, input bit inj_clear, input string tag);
        int nsamp, lastc, total, k, k3, bad_t, bad_d;
        bit exp_s, exp_d;
        logic [15:0] g16;
        cfg_write(CONF_ITER, iter);
        cfg_write(CONF_PER, per);
        cfg_write(CONF_DELAY, delay);
        cfg_write(CONF_SHIFT, shift);
`ifdef XYOLO_VMAC_LEAKY_EN
        cfg_write(CONF_LEAKY, int'(leaky_on));
`endif
        nsamp = iter * per;
        lastc = 2 + delay + nsamp - 1;
        total = lastc + 5;
        bad_t = 0;
        bad_d = 0;
        for (int rel = 0; rel < total; rel++) begin
            run   = (rel == 0) || (inj_run && rel == 3 + delay);
            clear = inj_clear && (rel == 2 + delay);
            k = rel - (2 + delay);
            if (k >= 0 && k < nsamp) begin
                g16 = 16'($urandom);
                pix = {g16, pix_a[k]};
                for (int l = 0; l < NL; l++) begin
                    g16 = 16'($urandom);
                    wgt[(NL-1-l)*DW +: DW]  = {g16, w_a[l][k]};
                    bias[(NL-1-l)*DW +: DW] = (k % per == 0) ? bias_a[k/per][l] : int'($urandom);
                end
            end else begin
                pix  = $urandom;
                wgt  = {$urandom, $urandom, $urandom, $urandom};
                bias = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            k3    = rel - 5 - delay;
            exp_s = (k3 >= 0) && (k3 < nsamp) && (k3 % per == per - 1);
            exp_d = (rel == 0) || (rel >= lastc + 4);
            if (fov !== exp_s) bad_t++;
            if (done !== exp_d) bad_d++;
            if (exp_s && fov)
                for (int l = 0; l < NL; l++)
                    check($sformatf("%s p%0d lane%0d", tag, k3 / per, l), lane_out(l),
                          longint'(model(l, k3 / per, per, shift)));
            tick();
        end
        run   = 1'b0;
        clear = 1'b0;
        check({tag, " strobe timing errs"}, bad_t, 0);
        check({tag, " done timing errs"}, bad_d, 0);
    endtask

    // A run that must be ignored: done stays high, no strobe.
    task automatic expect_noop(input string tag);
        int bad;
        bad = 0;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!done || fov) bad++;
            tick();
        end
        check({tag, " noop errs"}, bad, 0);
    endtask

    initial begin
        int bad, it, pe;
        vecs[0] = '{4, 0, 0,   10,      2,     1,   1,     30};
        vecs[1] = '{8, 0, 0,    0,  32767, 32767,   0,  32767};
        vecs[2] = '{8, 0, 0,    0, -32768, 32767,   0, -32768};
        vecs[3] = '{2, 1, 0,   -7,      3,     1,   0,     -1};
        vecs[4] = '{1, 4, 0, 1000,     -5,    20,   0,     56};
        vecs[5] = '{3, 0, 2,    0,     -1,   100, 100,   -600};
        vecs[6] = '{2, 2, 1, -100,      0,     5,   0,    -25};

        rst = 1'b1; clear = 1'b0; run = 1'b0;
        pix = '0; bias = '0; wgt = '0;
        cpu_if.valid = 1'b0; cpu_if.wstrb = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset done", longint'(done), 1);
        check("reset valid", longint'(fov), 0);
        check("reset flow_out", longint'(fo != '0), 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            fill_const(1, vecs[i].per, vecs[i].bias, vecs[i].w, vecs[i].pix0, vecs[i].step);
            run_job(1, vecs[i].per, vecs[i].shift, vecs[i].delay, 1'b0, 1'b0,
                    $sformatf("vec%0d", i));
            for (int l = 0; l < NL; l++)
                check($sformatf("vec%0d hold lane%0d", i, l), lane_out(l), longint'(vecs[i].expv));
        end

        // Three periods, distinct bias each, with a stray run mid-ACC.
        fill_const(3, 2, 0, 1, 2, 0);
        bias_a[0] = '{100, 100, 100, 100};
        bias_a[1] = '{200, 200, 200, 200};
        bias_a[2] = '{-300, -300, -300, -300};
        run_job(3, 2, 1, 0, 1'b1, 1'b0, "iter3");
        check("iter3 last lane0", lane_out(0), -148);

        // ITER==0 and PER==0 runs are no-ops.
        cfg_write(CONF_ITER, 0);
        cfg_write(CONF_PER, 4);
        expect_noop("iter0");
        cfg_write(CONF_ITER, 2);
        cfg_write(CONF_PER, 0);
        expect_noop("per0");

        // clear during a run hits config only; the run completes, a later run is a no-op.
        fill_const(2, 3, 7, 2, 3, 1);
        run_job(2, 3, 0, 1, 1'b0, 1'b1, "clear");
        expect_noop("after clear");

        // rst during ACC: immediate reset, then a fresh job works.
        cfg_write(CONF_ITER, 2);
        cfg_write(CONF_PER, 4);
        cfg_write(CONF_DELAY, 0);
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("rst done", longint'(done), 1);
        check("rst valid", longint'(fov), 0);
        check("rst flow_out", longint'(fo != '0), 0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fov || !done) bad++;
            tick();
        end
        check("post rst quiet errs", bad, 0);
        fill_const(1, 4, 10, 2, 1, 1);
        run_job(1, 4, 0, 0, 1'b0, 1'b0, "post rst");

`ifdef XYOLO_VMAC_LEAKY_EN
        fill_const(1, 1, -1000, 0, 0, 0);
        leaky_on = 1'b1;
        run_job(1, 1, 0, 0, 1'b0, 1'b0, "leaky1 neg");
        check("leaky1 neg lane0", lane_out(0), -102);
        leaky_on = 1'b0;
        run_job(1, 1, 0, 0, 1'b0, 1'b0, "leaky0 neg");
        check("leaky0 neg lane0", lane_out(0), -1000);
        fill_const(1, 1, 500, 0, 0, 0);
        leaky_on = 1'b1;
        run_job(1, 1, 0, 0, 1'b0, 1'b0, "leaky1 pos");
        check("leaky1 pos lane0", lane_out(0), 500);
        leaky_on = 1'b0;
`endif

        // Random jobs.
        for (int j = 0; j < 12; j++) begin
            it = $urandom_range(1, 4);
            pe = $urandom_range(1, 5);
            for (int p = 0; p < it; p++)
                for (int l = 0; l < NL; l++) bias_a[p][l] = int'($urandom);
            for (int k = 0; k < it * pe; k++) begin
                pix_a[k] = shortint'($urandom);
                for (int l = 0; l < NL; l++) w_a[l][k] = shortint'($urandom);
            end
            run_job(it, pe, $urandom_range(0, 8), $urandom_range(0, 3),
                    (it * pe >= 2) && ($urandom_range(0, 1) == 1), 1'b0, $sformatf("rnd%0d", j));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
